// File: rtl/pipe_type_display.sv
// Snapshots the per-stage two-character type codes and streams them, one
// character per handshake, to the debug text display. Optional macro: STAGE_LABEL_EN.
module pipe_type_display #(
    parameter int NSTAGES   = 5,
    parameter int START_COL = 0,
    parameter int AW        = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [16*NSTAGES-1:0]  types_in,
    input  logic                   snap,
    input  logic                   char_ready,
    output logic                   char_valid,
    output logic [7:0]             char_data,
    output logic [AW-1:0]          char_addr,
    output logic                   busy,
    output logic                   done
);

`ifdef STAGE_LABEL_EN
    localparam int GL = 4;
`else
    localparam int GL = 3;
`endif
    localparam int SW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [16*NSTAGES-1:0]  shadow_reg, shadow_next;
    logic [SW-1:0]          stage_reg, stage_next;
    logic [1:0]             pos_reg, pos_next;
    logic                   pending_reg, pending_next;
    logic [7:0]             data_reg, data_next;
    logic [AW-1:0]          addr_reg, addr_next;
    logic                   latch;
    logic                   last_char;

    // Character at (stage, position-within-group) of a code vector.
    function automatic logic [7:0] char_at(input logic [16*NSTAGES-1:0] src,
                                           input logic [SW-1:0] stg,
                                           input logic [1:0] pos);
        logic [15:0] code;
        logic [7:0]  c;
        code = 16'h2020;
        for (int s = 0; s < NSTAGES; s++) begin
            if (stg == SW'(s)) code = src[16*s +: 16];
        end
`ifdef STAGE_LABEL_EN
        case (pos)
            2'd0: begin
                case (int'(stg))
                    0:       c = 8'h46;
                    1:       c = 8'h44;
                    2:       c = 8'h45;
                    3:       c = 8'h4D;
                    4:       c = 8'h57;
                    default: c = 8'h30 + 8'(stg);
                endcase
            end
            2'd1:    c = code[15:8];
            2'd2:    c = code[7:0];
            default: c = 8'h20;
        endcase
`else
        case (pos)
            2'd0:    c = code[15:8];
            2'd1:    c = code[7:0];
            default: c = 8'h20;
        endcase
`endif
        return c;
    endfunction

    // The final stage has no trailing separator, so the line ends one short of a group.
    assign last_char = (stage_reg == SW'(NSTAGES-1)) && (pos_reg == 2'(GL-2));

    always_comb begin
        state_next   = state_reg;
        shadow_next  = shadow_reg;
        stage_next   = stage_reg;
        pos_next     = pos_reg;
        pending_next = pending_reg;
        data_next    = data_reg;
        addr_next    = addr_reg;
        latch        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (snap) latch = 1'b1;
            end
            SEND: begin
                if (snap) pending_next = 1'b1;
                if (char_ready) begin
                    if (last_char) begin
                        state_next = DONE;
                    end else begin
                        if (pos_reg == 2'(GL-1)) begin
                            pos_next   = 2'd0;
                            stage_next = stage_reg + 1'b1;
                        end else begin
                            pos_next = pos_reg + 1'b1;
                        end
                        addr_next = addr_reg + 1'b1;
                        data_next = char_at(shadow_reg, stage_next, pos_next);
                    end
                end
            end
            DONE: begin
                // A snap arriving on this very edge is folded into the re-latch.
                pending_next = 1'b0;
                if (pending_reg || snap) latch = 1'b1;
                else state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (latch) begin
            state_next  = SEND;
            shadow_next = types_in;
            stage_next  = '0;
            pos_next    = 2'd0;
            data_next   = char_at(types_in, '0, 2'd0);
            addr_next   = AW'(START_COL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            shadow_reg  <= {(2*NSTAGES){8'h20}};
            stage_reg   <= '0;
            pos_reg     <= 2'd0;
            pending_reg <= 1'b0;
            data_reg    <= 8'h20;
            addr_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            shadow_reg  <= shadow_next;
            stage_reg   <= stage_next;
            pos_reg     <= pos_next;
            pending_reg <= pending_next;
            data_reg    <= data_next;
            addr_reg    <= addr_next;
        end
    end

    assign char_valid = (state_reg == SEND);
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign char_data  = data_reg;
    assign char_addr  = addr_reg;

endmodule

// File: tb/tb_pipe_type_display.sv
// Randomised self-checking bench for pipe_type_display; expected lines are built
// by string assembly from the stage codes.
module tb_pipe_type_display;
    localparam int N  = 5;
    localparam int AW = 6;
`ifdef STAGE_LABEL_EN
    localparam int START = 8;
    localparam int L     = 4*N-1;
`else
    localparam int START = 0;
    localparam int L     = 3*N-1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [16*N-1:0]   types_in;
    logic              snap;
    logic              char_ready;
    logic              char_valid;
    logic [7:0]        char_data;
    logic [AW-1:0]     char_addr;
    logic              busy;
    logic              done;

    pipe_type_display #(.NSTAGES(N), .START_COL(START), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .types_in(types_in), .snap(snap),
        .char_ready(char_ready), .char_valid(char_valid), .char_data(char_data),
        .char_addr(char_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    got_d[$], exp_d[$];
    logic [AW-1:0] got_a[$], exp_a[$];
    int done_cnt, hold_errs, first_valid, last_valid, first_done, idle_cyc, stall_cyc;
    logic [7:0]    stall_d;
    logic [AW-1:0] stall_a;
    bit timed_out;
    logic [7:0] lbl [5] = '{8'h46, 8'h44, 8'h45, 8'h4D, 8'h57};

    // Reference: a line is the concatenation of per-stage groups.
    task automatic add_expected(input logic [16*N-1:0] t);
        int k;
        k = 0;
        for (int s = 0; s < N; s++) begin
`ifdef STAGE_LABEL_EN
            exp_d.push_back(s < 5 ? lbl[s] : 8'(8'h30 + s));
            exp_a.push_back(AW'(START + k)); k++;
`endif
            exp_d.push_back(t[16*s+8 +: 8]); exp_a.push_back(AW'(START + k)); k++;
            exp_d.push_back(t[16*s +: 8]);   exp_a.push_back(AW'(START + k)); k++;
            if (s < N-1) begin
                exp_d.push_back(8'h20); exp_a.push_back(AW'(START + k)); k++;
            end
        end
    endtask

    function automatic logic [16*N-1:0] fill(input logic [15:0] code);
        logic [16*N-1:0] t;
        for (int s = 0; s < N; s++) t[16*s +: 16] = code;
        return t;
    endfunction

    function automatic logic [16*N-1:0] rand_types();
        logic [16*N-1:0] t;
        for (int s = 0; s < N; s++) t[16*s +: 16] = 16'($urandom);
        return t;
    endfunction

    task automatic do_snap();
        snap = 1'b1;
        @(posedge clk); #1;
        snap = 1'b0;
    endtask

    // Drives char_ready and records accepted characters until busy falls.
    // mode 0: always ready, 1: random ready, 2: stall 3 cycles at index 4.
    task automatic collect(input int mode);
        int cyc, acc;
        logic r, pv, pr;
        logic [7:0] pd;
        logic [AW-1:0] pa;
        got_d.delete(); got_a.delete();
        done_cnt = 0; hold_errs = 0; first_valid = 0; last_valid = 0;
        first_done = 0; idle_cyc = 0; stall_cyc = 0; timed_out = 0;
        cyc = 0; acc = 0; pv = 0; pr = 0; pd = 0; pa = 0;
        while (1) begin
            cyc++;
            if (cyc > 400) begin timed_out = 1; break; end
            if (pv && !pr && char_valid && (char_data !== pd || char_addr !== pa)) hold_errs++;
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = cyc;
            end
            if (!busy) begin idle_cyc = cyc; break; end
            if (mode == 0) r = 1'b1;
            else if (mode == 1) r = 1'($urandom_range(0, 1));
            else r = !(acc == 4 && char_valid && stall_cyc < 3);
            if (mode == 2 && !r) begin
                stall_cyc++; stall_d = char_data; stall_a = char_addr;
            end
            char_ready = r;
            if (char_valid) begin
                if (first_valid == 0) first_valid = cyc;
                last_valid = cyc;
                if (r) begin
                    got_d.push_back(char_data); got_a.push_back(char_addr); acc++;
                end
            end
            pv = char_valid; pr = r; pd = char_data; pa = char_addr;
            @(posedge clk); #1;
        end
        char_ready = 1'b0;
        if (timed_out) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: busy still %0b after 400 cycles, required 0", busy);
        end
    endtask

    task automatic test_reset();
        n_checks++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b required 0", char_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b required 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b required 0", done); end
        n_checks++; if (char_data !== 8'h20) begin n_fail++; $display("FAIL reset_data: got %h required 20", char_data); end
        n_checks++; if (char_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d required 0", char_addr); end
        $display("test_reset done");
    endtask

    task automatic test_basic_line();
        logic [16*N-1:0] t;
        t = {"0D", "0C", "xx", "01", "0B"};
        types_in = t;
        exp_d.delete(); exp_a.delete(); add_expected(t);
        do_snap();
        collect(0);
        n_checks++; if (got_d.size() != exp_d.size()) begin n_fail++; $display("FAIL basic_len: got %0d required %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i]) begin
                n_fail++; $display("FAIL basic_char[%0d]: got %h@%0d required %h@%0d", i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
            end
        end
        n_checks++; if (first_valid != 1 || last_valid != L) begin n_fail++; $display("FAIL basic_valid_window: got %0d..%0d required 1..%0d", first_valid, last_valid, L); end
        n_checks++; if (first_done != L+1 || done_cnt != 1) begin n_fail++; $display("FAIL basic_done: got cycle %0d count %0d required cycle %0d count 1", first_done, done_cnt, L+1); end
        n_checks++; if (idle_cyc != L+2) begin n_fail++; $display("FAIL basic_idle: got cycle %0d required %0d", idle_cyc, L+2); end
        $display("test_basic_line: %0d chars accepted", got_d.size());
    endtask

    task automatic test_backpressure();
        logic [16*N-1:0] t;
        t = rand_types();
        types_in = t;
        exp_d.delete(); exp_a.delete(); add_expected(t);
        do_snap();
        collect(2);
        n_checks++; if (stall_cyc != 3 || hold_errs != 0) begin n_fail++; $display("FAIL bp_hold: got %0d stall cycles %0d hold errors required 3 and 0", stall_cyc, hold_errs); end
        n_checks++; if (stall_d !== exp_d[4] || stall_a !== exp_a[4]) begin n_fail++; $display("FAIL bp_stall_char: got %h@%0d required %h@%0d", stall_d, stall_a, exp_d[4], exp_a[4]); end
        n_checks++; if (got_d.size() != exp_d.size()) begin n_fail++; $display("FAIL bp_len: got %0d required %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i]) begin
                n_fail++; $display("FAIL bp_char[%0d]: got %h@%0d required %h@%0d", i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
            end
        end
        $display("test_backpressure: %0d stall cycles", stall_cyc);
    endtask

    task automatic test_coherence();
        logic [16*N-1:0] t;
        t = rand_types();
        types_in = t;
        exp_d.delete(); exp_a.delete(); add_expected(t);
        do_snap();
        types_in = fill("1F");
        collect(1);
        n_checks++; if (got_d.size() != exp_d.size()) begin n_fail++; $display("FAIL coh_len: got %0d required %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i]) begin
                n_fail++; $display("FAIL coh_char[%0d]: got %h@%0d required %h@%0d", i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
            end
        end
        $display("test_coherence: line of %0d chars", got_d.size());
    endtask

    task automatic test_snap_while_busy();
        logic [16*N-1:0] t;
        t = rand_types();
        types_in = t;
        exp_d.delete(); exp_a.delete(); add_expected(t); add_expected(fill("10"));
        do_snap();
        fork
            collect(1);
            begin
                repeat (3) @(posedge clk);
                #1 types_in = fill("10");
                do_snap();
                repeat (2) @(posedge clk);
                #1 do_snap();
            end
        join
        n_checks++; if (done_cnt != 2) begin n_fail++; $display("FAIL swb_done_count: got %0d required 2", done_cnt); end
        n_checks++; if (got_d.size() != exp_d.size()) begin n_fail++; $display("FAIL swb_len: got %0d required %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i]) begin
                n_fail++; $display("FAIL swb_char[%0d]: got %h@%0d required %h@%0d", i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL swb_idle: busy got %0b required 0", busy); end
        $display("test_snap_while_busy: %0d chars, %0d done pulses", got_d.size(), done_cnt);
    endtask

    task automatic test_async_reset();
        logic [16*N-1:0] t;
        t = rand_types();
        types_in = t;
        do_snap();
        fork
            collect(0);
            begin
                repeat (7) @(posedge clk);
                #3 rst_n = 1'b0;
                #1;
                n_checks++; if (char_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++; $display("FAIL arst_drop: valid/busy/done got %0b%0b%0b required 000", char_valid, busy, done);
                end
            end
        join
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL arst_no_done: got %0d done pulses required 0", done_cnt); end
        n_checks++; if (char_data !== 8'h20 || char_addr !== '0) begin n_fail++; $display("FAIL arst_outputs: got %h@%0d required 20@0", char_data, char_addr); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        t = rand_types();
        types_in = t;
        exp_d.delete(); exp_a.delete(); add_expected(t);
        do_snap();
        collect(0);
        n_checks++; if (done_cnt != 1 || got_d.size() != exp_d.size()) begin n_fail++; $display("FAIL arst_restart: got %0d chars %0d done required %0d chars 1 done", got_d.size(), done_cnt, exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i]) begin
                n_fail++; $display("FAIL arst_char[%0d]: got %h@%0d required %h@%0d", i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
            end
        end
        $display("test_async_reset: restart line of %0d chars", got_d.size());
    endtask

    task automatic test_random_lines();
        logic [16*N-1:0] t;
        for (int n = 0; n < 4; n++) begin
            t = rand_types();
            types_in = t;
            exp_d.delete(); exp_a.delete(); add_expected(t);
            do_snap();
            collect(1);
            n_checks++; if (done_cnt != 1 || got_d.size() != exp_d.size()) begin n_fail++; $display("FAIL rand_line%0d: got %0d chars %0d done required %0d chars 1 done", n, got_d.size(), done_cnt, exp_d.size()); end
            for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
                n_checks++;
                if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i]) begin
                    n_fail++; $display("FAIL rand_char%0d[%0d]: got %h@%0d required %h@%0d", n, i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
                end
            end
            $display("test_random_lines: line %0d, %0d chars", n, got_d.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; snap = 1'b0; char_ready = 1'b0; types_in = '0;
        #12;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic_line();
        test_backpressure();
        test_coherence();
        test_snap_while_busy();
        test_async_reset();
        test_random_lines();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_type_display.md
Name: pipe_type_display

Overview:
- Consumes the 16-bit, two-character ASCII instruction-type codes that the per-stage type decoders produce for IF, ID, EX, MEM and WB. A bubble stage carries "xx".
- On a snapshot request it latches all stage codes in the same cycle. It then serialises them, one character per handshake, to the character-display writer.
- Sits between the pipeline's per-stage type decoders and the debug text display. The displayed line is therefore a coherent picture of one clock cycle.

Parameters:
- NSTAGES, 5, number of stage codes on types_in; stage 0 = IF.
- START_COL, 0, display column of the first emitted character.
- AW, 6, width of char_addr; START_COL + line length must fit.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- types_in  in  16*NSTAGES  stage codes; stage s occupies bits [16s+15:16s]; high byte = first character.
- snap  in  1  snapshot request, sampled each cycle.
- char_ready  in  1  display writer accepts the current character.
- char_valid  out  1  character present on char_data/char_addr.
- char_data  out  8  ASCII character.
- char_addr  out  AW  display column.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse after the last character is accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - char_valid, busy, done, pending = 0.
  - char_data = 8'h20, char_addr = 0.
  - Shadow register cleared to all 8'h20.
- Per-stage group: hi char, lo char, then separator 8'h20. The last stage has no separator.
- Line length L = 3*NSTAGES-1 (14 at default). Characters are emitted in stage order 0..NSTAGES-1, at char_addr = START_COL + index, index 0..L-1.
- States:
  - IDLE: on snap=1 at edge t, latch types_in into the shadow register, index=0, go SEND. From cycle t+1, char_valid=1, busy=1, and the outputs show index 0.
  - SEND: char_valid=1. char_data and char_addr are held stable until char_ready=1 at a rising edge.
    - On a handshake: if index<L-1, index+1 and the next character is presented the following cycle (back-to-back transfers allowed, one per cycle). If index=L-1, go DONE.
  - DONE: char_valid=0, done=1 for exactly one cycle, busy=1.
    - If pending=1: re-latch types_in at this edge, clear pending, go SEND.
    - Otherwise go IDLE.
- snap while busy (SEND/DONE): sets pending. Further snaps merge; the queue is one-deep.
  - A snap in the same cycle as the DONE-state edge is served by that re-latch; pending stays 0.
  - The shadow register is never overwritten mid-line.
- char_ready while char_valid=0 is ignored.
- busy deasserts only in IDLE.
- rst_n asserted mid-line: immediate abort to reset values. No done pulse; pending is lost.
- Characters are passed unmodified; the block does not check for ASCII validity.

Optional Feature:
- STAGE_LABEL_EN defined: each group is prefixed with a stage label character 'F','D','E','M','W' for stages 0-4; stages 5 and above use '0'+s.
  - Group = label, hi, lo, space.
  - L = 4*NSTAGES-1 (19 at default).
- Not defined: groups are hi, lo, space only, and L = 3*NSTAGES-1. No label logic is present.

Test Plan:
- Basic line, default build:
  - Stimulus: types_in = IF "0B", ID "01", EX "xx", MEM "0C", WB "0D"; char_ready tied 1; snap pulse at cycle 0.
  - Response: char_valid high cycles 1-14, with chars "0B 01 xx 0C 0D" at addr 0..13; done pulse at cycle 15; busy low at cycle 16.
- Backpressure:
  - Stimulus: char_ready low for 3 cycles at index 4.
  - Response: char_data='1', char_addr=4 held stable all 3 cycles; no character skipped or repeated.
- Snapshot coherence:
  - Stimulus: types_in changed to all "1F" after the snap edge.
  - Response: the emitted line still matches the original values.
- Snap while busy:
  - Stimulus: two snaps during SEND with types_in = "10" on every stage.
  - Response: after done, exactly one further line "10 10 10 10 10", then a second done, then IDLE.
- Async reset:
  - Stimulus: rst_n low at index 7, not clock-aligned.
  - Response: char_valid, busy and done drop immediately; no done pulse; a fresh snap restarts at index 0.
- STAGE_LABEL_EN build:
  - Stimulus: same as the basic line, START_COL=8.
  - Response: "F0B D01 Exx M0C W0D" on addr 8..26; done after the 19th accept.
